// File: rtl/div_unit_pkg.sv
// Shared constants and types for the iterative restoring divider.
package div_unit_pkg;

    // One-hot div_op bit positions
    localparam int unsigned DIV_W  = 0;
    localparam int unsigned DIV_WU = 1;
    localparam int unsigned MOD_W  = 2;
    localparam int unsigned MOD_WU = 3;

    localparam logic [31:0] DIV_ZERO_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract, restore on borrow.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, msb_i};
        diff    = shifted - {1'b0, divisor_i};
        // rem_i < divisor keeps a successful difference below 2^WIDTH, so the top bit is the borrow
        q_bit_o = ~diff[WIDTH];
        rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for div.w/div.wu/mod.w/mod.wu with valid/ready ports.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       div_op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned    CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]  LastCnt = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             sx_q, sx_d, sy_q, sy_d, mod_q, mod_d, dz_q, dz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             is_signed;
    logic [WIDTH-1:0] q_fin, q_fix, r_fix;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .msb_i     (quo_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        mod_d    = mod_q;
        dz_d     = dz_q;

        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StDone);

        is_signed = div_op[DIV_W] | div_op[MOD_W];
        q_fin     = {quo_q[WIDTH-2:0], step_q};
        q_fix     = (sx_q ^ sy_q) ? -q_fin : q_fin;
        // With a zero divisor every trial succeeds and the remainder ends as |x|; after the
        // sign fixup it equals the original x, so only the quotient needs the override.
        r_fix     = sx_q ? -step_rem : step_rem;

        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        sx_d    = is_signed & x[WIDTH-1];
                        sy_d    = is_signed & y[WIDTH-1];
                        mod_d   = div_op[MOD_W] | div_op[MOD_WU];
                        quo_d   = (is_signed & x[WIDTH-1]) ? -x : x;
                        dvs_d   = (is_signed & y[WIDTH-1]) ? -y : y;
                        rem_d   = '0;
                        cnt_d   = '0;
                        dz_d    = (y == '0);
                        state_d = StCalc;
                    end
                end
                StCalc: begin
                    rem_d = step_rem;
                    quo_d = q_fin;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        cnt_d    = '0;
                        result_d = mod_q ? r_fix : (dz_q ? WIDTH'(DIV_ZERO_RESULT) : q_fix);
                        state_d  = StDone;
                    end
                end
                StDone: begin
                    if (resp_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            mod_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            mod_q    <= mod_d;
            dz_q     <= dz_d;
        end
    end

    assign result = result_q;

endmodule
